// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared constants for the instruction-fetch stage: exception codes, the
// default reset/exception vectors, default legal fetch window and the fetch
// FSM state encoding.
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  // CP0 ExcCode values produced by the fetch stage.
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  // Default vectors and legal instruction-memory window.
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;
  localparam logic [31:0] IMEM_LO  = 32'h0000_3000;
  localparam logic [31:0] IMEM_HI  = 32'h0000_6FFC;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,  // present pc_f to memory (or flag AdEL)
    ST_WAIT  = 2'd1,  // request accepted, waiting for read data
    ST_HOLD  = 2'd2   // instruction available, waiting for the PC to move
  } fetch_state_e;

endpackage

// File: rtl/fetch_npc.sv
// -----------------------------------------------------------------------------
// fetch_npc
// Combinational next-PC priority mux for the fetch stage (below reset, which
// is handled by the PC register itself):
//   req -> EXC_PC, eret_d&en_f -> epc, branch_taken&en_f -> branch_target,
//   en_f&hold -> pc_f+4, otherwise pc_f holds.
// Ports:
//   req, eret_d, branch_taken, en_f, hold  redirect / advance conditions
//   pc_f, epc, branch_target               candidate addresses
//   npc                                    selected next PC
//   load                                   1 when the PC changes this cycle
// -----------------------------------------------------------------------------
module fetch_npc #(
  parameter logic [31:0] EXC_PC = fetch_unit_pkg::EXC_PC
) (
  input  logic        req,
  input  logic        eret_d,
  input  logic        branch_taken,
  input  logic        en_f,
  input  logic        hold,
  input  logic [31:0] pc_f,
  input  logic [31:0] epc,
  input  logic [31:0] branch_target,
  output logic [31:0] npc,
  output logic        load
);

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    npc  = pc_f;
    load = 1'b0;
    if (req) begin
      npc  = EXC_PC;
      load = 1'b1;
    end else if (en_f && eret_d) begin
      npc  = epc;
      load = 1'b1;
    end else if (en_f && branch_taken) begin
      npc  = branch_target;
      load = 1'b1;
    end else if (en_f && hold) begin
      npc  = pc_f + 32'd4;
      load = 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// IF stage: owns the PC, fetches over a variable-latency imem handshake with
// at most one outstanding request, flags AdEL on illegal fetch addresses and
// drives the F-side inputs of the F/D register.
//
// Configuration: define FETCH_RANGE_CHECK_EN to also raise AdEL for aligned
// addresses outside [IMEM_LO, IMEM_HI]; by default only misalignment does.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   en_f                        F/D register captures this cycle
//   req                         exception taken -> EXC_PC
//   eret_d, epc                 eret in D -> epc
//   branch_taken, branch_target D-stage redirect
//   jump_d                      F instruction is a delay slot
//   imem_req/addr/ready         request channel
//   imem_rvalid/rdata           response channel
//   pc_f, instr_f, exc_f, bd_f  F-stage outputs
//   fetch_busy                  instruction not yet held; front end must stall
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = fetch_unit_pkg::RESET_PC,
  parameter logic [31:0] EXC_PC   = fetch_unit_pkg::EXC_PC,
  parameter logic [31:0] IMEM_LO  = fetch_unit_pkg::IMEM_LO,
  parameter logic [31:0] IMEM_HI  = fetch_unit_pkg::IMEM_HI
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_f,
  input  logic        req,
  input  logic        eret_d,
  input  logic [31:0] epc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_d,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] instr_f,
  output logic [4:0]  exc_f,
  output logic        bd_f,
  output logic        fetch_busy
);
  import fetch_unit_pkg::*;

`ifdef FETCH_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  fetch_state_e state, state_n;
  logic         discard, discard_n;
  logic [31:0]  instr_n;
  logic [4:0]   exc_n;
  logic [31:0]  npc;
  logic         pc_load;
  logic         pc_legal;
  logic         outstanding;

  assign pc_legal = (pc_f[1:0] == 2'b00) &&
                    (!RANGE_CHECK || ((pc_f >= IMEM_LO) && (pc_f <= IMEM_HI)));

  fetch_npc #(.EXC_PC(EXC_PC)) u_npc (
    .req           (req),
    .eret_d        (eret_d),
    .branch_taken  (branch_taken),
    .en_f          (en_f),
    .hold          (state == ST_HOLD),
    .pc_f          (pc_f),
    .epc           (epc),
    .branch_target (branch_target),
    .npc           (npc),
    .load          (pc_load)
  );

  assign imem_addr  = pc_f;
  assign fetch_busy = (state != ST_HOLD);
  assign bd_f       = jump_d & ~req & ~eret_d;

  always_comb begin
    state_n     = state;
    discard_n   = discard;
    instr_n     = instr_f;
    exc_n       = exc_f;
    imem_req    = 1'b0;
    outstanding = 1'b0;  // a response will still arrive after this edge

    unique case (state)
      ST_ISSUE: begin
        if (pc_legal) begin
          imem_req = ~reset;
          if (imem_req && imem_ready) begin
            state_n     = ST_WAIT;
            outstanding = 1'b1;
          end
        end else begin
          instr_n = '0;
          exc_n   = EXC_ADEL;
          state_n = ST_HOLD;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (discard) begin
            discard_n = 1'b0;
            state_n   = ST_ISSUE;
          end else begin
            instr_n = imem_rdata;
            exc_n   = EXC_INT;
            state_n = ST_HOLD;
          end
        end else begin
          outstanding = 1'b1;
        end
      end
      ST_HOLD: ;
      default: state_n = ST_ISSUE;
    endcase

    // A PC change restarts the fetch. If a response is still owed for the old
    // PC we park in WAIT with discard set, so that response is swallowed and
    // the new PC is only presented once the memory is idle again.
    if (pc_load) begin
      instr_n   = '0;
      exc_n     = EXC_INT;
      state_n   = outstanding ? ST_WAIT : ST_ISSUE;
      discard_n = outstanding;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f    <= RESET_PC;
      state   <= ST_ISSUE;
      discard <= 1'b0;
      instr_f <= '0;
      exc_f   <= EXC_INT;
    end else begin
      pc_f    <= npc;
      state   <= state_n;
      discard <= discard_n;
      instr_f <= instr_n;
      exc_f   <= exc_n;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. The instruction memory is driven by hand, one
// step at a time; every expected value is written out explicitly.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        en_f;
  logic        req;
  logic        eret_d;
  logic [31:0] epc;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_d;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_f;
  logic [31:0] instr_f;
  logic [4:0]  exc_f;
  logic        bd_f;
  logic        fetch_busy;

  int n_total = 0;
  int n_pass  = 0;

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .en_f          (en_f),
    .req           (req),
    .eret_d        (eret_d),
    .epc           (epc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump_d        (jump_d),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .pc_f          (pc_f),
    .instr_f       (instr_f),
    .exc_f         (exc_f),
    .bd_f          (bd_f),
    .fetch_busy    (fetch_busy)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after input changes before checking.
  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; en_f = 1'b0; req = 1'b0; eret_d = 1'b0; epc = '0;
    branch_taken = 1'b0; branch_target = '0; jump_d = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    // Reset state.
    cyc(); cyc(); settle();
    check("rst_pc",    pc_f,              32'h0000_3000);
    check("rst_instr", instr_f,           32'h0);
    check("rst_exc",   32'(exc_f),        32'd0);
    check("rst_bd",    32'(bd_f),         32'd0);
    check("rst_req",   32'(imem_req),     32'd0);
    check("rst_busy",  32'(fetch_busy),   32'd1);

    // First fetch at 0x3000, one-cycle latency.
    reset = 1'b0; imem_ready = 1'b1; settle();
    check("f0_req",  32'(imem_req), 32'd1);
    check("f0_addr", imem_addr,     32'h0000_3000);
    cyc(); imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2408_0001; settle();
    check("f0_wait_req",  32'(imem_req),   32'd0);
    check("f0_wait_busy", 32'(fetch_busy), 32'd1);
    cyc(); imem_rvalid = 1'b0; settle();
    check("f0_instr", instr_f,          32'h2408_0001);
    check("f0_exc",   32'(exc_f),       32'd0);
    check("f0_busy",  32'(fetch_busy),  32'd0);
    en_f = 1'b1;
    cyc(); en_f = 1'b0; settle();
    check("adv_pc",    pc_f,             32'h0000_3004);
    check("adv_instr", instr_f,          32'h0);
    check("adv_busy",  32'(fetch_busy),  32'd1);
    check("adv_addr",  imem_addr,        32'h0000_3004);

    // Fetch 0x3004, then take a branch to 0x3010 from HOLD with a delay slot.
    imem_ready = 1'b1;
    cyc(); imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1000_0003;
    cyc(); imem_rvalid = 1'b0;
    jump_d = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_3010; en_f = 1'b1; settle();
    check("br_bd", 32'(bd_f), 32'd1);
    cyc(); jump_d = 1'b0; branch_taken = 1'b0; en_f = 1'b0; settle();
    check("br_pc",    pc_f,             32'h0000_3010);
    check("br_instr", instr_f,          32'h0);
    check("br_busy",  32'(fetch_busy),  32'd1);

    // Exception taken while the 0x3010 fetch is in flight.
    imem_ready = 1'b1; settle();
    check("exc_issue_addr", imem_addr, 32'h0000_3010);
    cyc(); imem_ready = 1'b0; req = 1'b1; jump_d = 1'b1; settle();
    check("exc_bd_forced", 32'(bd_f), 32'd0);
    cyc(); req = 1'b0; jump_d = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; settle();
    check("exc_pc",       pc_f,          32'h0000_4180);
    check("exc_hold_req", 32'(imem_req), 32'd0);
    cyc(); imem_rvalid = 1'b0; settle();
    check("exc_dropped",  instr_f,       32'h0);
    check("exc_req",      32'(imem_req), 32'd1);
    check("exc_addr",     imem_addr,     32'h0000_4180);
    imem_ready = 1'b1;
    cyc(); imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h4200_0018;
    cyc(); imem_rvalid = 1'b0; settle();
    check("exc_instr", instr_f,         32'h4200_0018);
    check("exc_busy",  32'(fetch_busy), 32'd0);

    // Misaligned branch target raises AdEL without a request.
    branch_taken = 1'b1; branch_target = 32'h0000_3002; en_f = 1'b1;
    cyc(); branch_taken = 1'b0; en_f = 1'b0; settle();
    check("mis_req", 32'(imem_req), 32'd0);
    check("mis_pc",  pc_f,          32'h0000_3002);
    cyc(); settle();
    check("mis_exc",   32'(exc_f),      32'd4);
    check("mis_instr", instr_f,         32'h0);
    check("mis_busy",  32'(fetch_busy), 32'd0);
    check("mis_pc_h",  pc_f,            32'h0000_3002);

    // Aligned but outside the instruction window.
    branch_taken = 1'b1; branch_target = 32'h0000_8000; en_f = 1'b1;
    cyc(); branch_taken = 1'b0; en_f = 1'b0; imem_ready = 1'b1; settle();
`ifdef FETCH_RANGE_CHECK_EN
    check("rng_req", 32'(imem_req), 32'd0);
    cyc(); imem_ready = 1'b0; settle();
    check("rng_exc", 32'(exc_f), 32'd4);
`else
    check("rng_req",  32'(imem_req), 32'd1);
    check("rng_addr", imem_addr,     32'h0000_8000);
    cyc(); imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h3C01_0000;
    cyc(); imem_rvalid = 1'b0; settle();
    check("rng_exc",   32'(exc_f), 32'd0);
    check("rng_instr", instr_f,    32'h3C01_0000);
`endif

    // eret: ignored while en_f = 0, taken when en_f = 1.
    eret_d = 1'b1; epc = 32'h0000_3020; jump_d = 1'b1; settle();
    check("eret_bd", 32'(bd_f), 32'd0);
    cyc(); settle();
    check("eret_stall_pc", pc_f, 32'h0000_8000);
    en_f = 1'b1;
    cyc(); en_f = 1'b0; eret_d = 1'b0; jump_d = 1'b0; settle();
    check("eret_pc",   pc_f,            32'h0000_3020);
    check("eret_busy", 32'(fetch_busy), 32'd1);

    // Reset during WAIT returns to a clean ISSUE at the reset vector.
    imem_ready = 1'b1;
    cyc(); imem_ready = 1'b0; reset = 1'b1;
    cyc(); settle();
    check("rw_pc",  pc_f,          32'h0000_3000);
    check("rw_req", 32'(imem_req), 32'd0);
    reset = 1'b0; settle();
    check("rw_reissue", 32'(imem_req), 32'd1);
    check("rw_addr",    imem_addr,     32'h0000_3000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
